// File: rtl/alu_share_pkg.sv
// Shared constants for the two-port ALU arbiter: widths, ALU op codes, FSM states.
package alu_share_pkg;

    localparam int unsigned ALU_WIDTH  = 64;
    localparam int unsigned ALU_CTRL_W = 2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu.sv
// Combinational Y-86 ALU: ADD/SUB/AND/XOR with signed overflow for ADD/SUB.
module alu
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned CTRL_W = ALU_CTRL_W
) (
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic              overflow
);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (ctrl)
            CTRL_W'(OP_ADD): begin
                result   = a + b;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            CTRL_W'(OP_SUB): begin
                // a - b overflows when a and -b share a sign the result does not
                result   = a - b;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            CTRL_W'(OP_AND): result = a & b;
            CTRL_W'(OP_XOR): result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant; last_grant resets to 1 so port 0 wins first contention.
module alu_rr_grant (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        last_grant_d = last_grant_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters and owns the ZF/SF/OF condition codes.
// Define ALU_SHARE_B2B_EN to allow a new accept on the same edge a response handshakes.
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req0_setcc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic              req1_setcc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_overflow,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);

    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              op_setcc_q, op_setcc_d;
    logic              op_id_q, op_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_overflow_q, rsp_overflow_d;
    logic              cc_zf_q, cc_zf_d;
    logic              cc_sf_q, cc_sf_d;
    logic              cc_of_q, cc_of_d;

    logic              grant_en;
    logic              gnt0, gnt1;
    logic              accept;
    logic              is_arith;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_overflow;

`ifdef ALU_SHARE_B2B_EN
    assign grant_en = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
`else
    assign grant_en = !rst && (state_q == ST_IDLE);
`endif

    alu_rr_grant u_grant (
        .clk  (clk),
        .rst  (rst),
        .en   (grant_en),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    alu #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_alu (
        .ctrl     (op_ctrl_q),
        .a        (op_a_q),
        .b        (op_b_q),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    assign accept   = gnt0 || gnt1;
    assign is_arith = (op_ctrl_q == CTRL_W'(OP_ADD)) || (op_ctrl_q == CTRL_W'(OP_SUB));

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign cc_zf        = cc_zf_q;
    assign cc_sf        = cc_sf_q;
    assign cc_of        = cc_of_q;

    // Next-state, operand capture, response capture and CC update
    always_comb begin
        state_d        = state_q;
        op_ctrl_d      = op_ctrl_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_setcc_d     = op_setcc_q;
        op_id_d        = op_id_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        cc_zf_d        = cc_zf_q;
        cc_sf_d        = cc_sf_q;
        cc_of_d        = cc_of_q;

        if (accept) begin
            op_ctrl_d  = gnt1 ? req1_ctrl  : req0_ctrl;
            op_a_d     = gnt1 ? req1_a     : req0_a;
            op_b_d     = gnt1 ? req1_b     : req0_b;
            op_setcc_d = gnt1 ? req1_setcc : req0_setcc;
            op_id_d    = gnt1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d        = ST_RESP;
                rsp_valid_d    = 1'b1;
                rsp_id_d       = op_id_q;
                rsp_result_d   = alu_result;
                rsp_overflow_d = alu_overflow;
                if (op_setcc_q) begin
                    cc_zf_d = (alu_result == '0);
                    cc_sf_d = alu_result[WIDTH-1];
                    cc_of_d = is_arith && alu_overflow;
                end
            end
            ST_RESP: begin
                // accept can only be high here when back-to-back issue is built in
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_ctrl_q      <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_setcc_q     <= 1'b0;
            op_id_q        <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            cc_zf_q        <= 1'b1;
            cc_sf_q        <= 1'b0;
            cc_of_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_ctrl_q      <= op_ctrl_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_setcc_q     <= op_setcc_d;
            op_id_q        <= op_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            cc_zf_q        <= cc_zf_d;
            cc_sf_q        <= cc_sf_d;
            cc_of_q        <= cc_of_d;
        end
    end

endmodule
